// File: rtl/t04_mem_request_ctrl_if.sv
// Bus-side signals shared by the memory request controller (master) and the
// instruction/data bus (slave).
interface t04_mem_request_ctrl_if #(
   parameter int ADDR_W = 32
);
   logic [ADDR_W-1:0] bus_addr;
   logic [31:0]       bus_wdata;
   logic [3:0]        bus_sel;
   logic              bus_ren;
   logic              bus_wen;
   logic              i_ack;
   logic              d_ack;
   logic [31:0]       bus_rdata;

   modport master (
      output bus_addr, bus_wdata, bus_sel, bus_ren, bus_wen,
      input  i_ack, d_ack, bus_rdata
   );

   modport slave (
      input  bus_addr, bus_wdata, bus_sel, bus_ren, bus_wen,
      output i_ack, d_ack, bus_rdata
   );
endinterface

// File: rtl/t04_mem_request_ctrl.sv
// Multi-cycle fetch / load / store sequencer for a simple core: one bus access
// per state, freeze stalls the datapath, wait-counter timeout parks in ERROR.
module t04_mem_request_ctrl #(
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   t04_mem_request_ctrl_if.master bus,
   input  logic [ADDR_W-1:0]      pc,
   input  logic [ADDR_W-1:0]      mem_addr,
   input  logic [31:0]            store_data,
   input  logic                   mem_read,
   input  logic                   mem_write,
   input  logic [1:0]             size,
   input  logic                   load_unsigned,
   output logic [31:0]            instruction_out,
   output logic [31:0]            load_data,
   output logic                   freeze,
   output logic                   misaligned,
   output logic                   timeout_err
);
   // A zero TIMEOUT still needs a legal (unused) counter width.
   localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   typedef enum logic [2:0] {
      FETCH = 3'd0,
      EXEC  = 3'd1,
      DATA  = 3'd2,
      WB    = 3'd3,
      ERROR = 3'd4
   } state_t;

   state_t           state_r;
   state_t           state_nxt_s;
   logic [CNT_W-1:0] wait_cnt_r;
   logic [31:0]      instr_r;
   logic [31:0]      load_r;
   logic             timeout_err_r;
   logic             mem_op_s;
   logic             is_load_s;
   logic             illegal_s;
   logic             timeout_hit_s;
   logic [31:0]      load_ext_s;

   function automatic logic access_illegal(input logic [1:0] sz, input logic [1:0] lo);
      case (sz)
         2'b00:   access_illegal = 1'b0;
         2'b01:   access_illegal = lo[0];
         2'b10:   access_illegal = (lo != 2'b00);
         default: access_illegal = 1'b1;
      endcase
   endfunction

   function automatic logic [3:0] lane_sel(input logic [1:0] sz, input logic [1:0] lo);
      case (sz)
         2'b00:   lane_sel = 4'b0001 << lo;
         2'b01:   lane_sel = 4'b0011 << lo;
         default: lane_sel = 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] wdata_pack(input logic [1:0] sz, input logic [31:0] d);
      case (sz)
         2'b00:   wdata_pack = {4{d[7:0]}};
         2'b01:   wdata_pack = {2{d[15:0]}};
         default: wdata_pack = d;
      endcase
   endfunction

   function automatic logic [31:0] load_align(input logic [1:0] sz, input logic [1:0] lo,
                                              input logic [31:0] rdata, input logic uns);
      logic [31:0] sh;
      sh = rdata >> {lo, 3'b000};
      case (sz)
         2'b00:   load_align = {{24{~uns & sh[7]}}, sh[7:0]};
         2'b01:   load_align = {{16{~uns & sh[15]}}, sh[15:0]};
         default: load_align = sh;
      endcase
   endfunction

   assign mem_op_s      = mem_read | mem_write;
   assign is_load_s     = mem_read & ~mem_write;
   assign illegal_s     = access_illegal(size, mem_addr[1:0]);
   assign timeout_hit_s = (TIMEOUT > 0) && (wait_cnt_r == CNT_LAST);
   assign load_ext_s    = load_align(size, mem_addr[1:0], bus.bus_rdata, load_unsigned);

   // Next-state and bus/handshake outputs; reset forces the idle bus pattern.
   always_comb begin
      state_nxt_s   = state_r;
      bus.bus_addr  = pc;
      bus.bus_wdata = wdata_pack(size, store_data);
      bus.bus_sel   = 4'b0000;
      bus.bus_ren   = 1'b0;
      bus.bus_wen   = 1'b0;
      freeze        = 1'b1;
      misaligned    = 1'b0;
      if (rst) begin
         state_nxt_s = FETCH;
      end else begin
         case (state_r)
            FETCH: begin
               bus.bus_ren = 1'b1;
               bus.bus_sel = 4'b1111;
               if (bus.i_ack) begin
                  state_nxt_s = EXEC;
               end else if (timeout_hit_s) begin
                  state_nxt_s = ERROR;
               end else begin
                  state_nxt_s = FETCH;
               end
            end
            EXEC: begin
               if (!mem_op_s) begin
                  freeze      = 1'b0;
                  state_nxt_s = FETCH;
               end else if (illegal_s) begin
                  misaligned  = 1'b1;
                  freeze      = 1'b0;
                  state_nxt_s = FETCH;
               end else begin
                  state_nxt_s = DATA;
               end
            end
            DATA: begin
               bus.bus_addr = {mem_addr[ADDR_W-1:2], 2'b00};
               bus.bus_ren  = is_load_s;
               bus.bus_wen  = mem_write;
               bus.bus_sel  = lane_sel(size, mem_addr[1:0]);
               if (bus.d_ack) begin
                  state_nxt_s = WB;
               end else if (timeout_hit_s) begin
                  state_nxt_s = ERROR;
               end else begin
                  state_nxt_s = DATA;
               end
            end
            WB: begin
               freeze      = 1'b0;
               state_nxt_s = FETCH;
            end
            ERROR: begin
               state_nxt_s = ERROR;
            end
            default: begin
               state_nxt_s = FETCH;
            end
         endcase
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= FETCH;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Ack wait counter: restarts on every state change, idles outside FETCH/DATA.
   always_ff @(posedge clk) begin
      if (rst) begin
         wait_cnt_r <= {CNT_W{1'b0}};
      end else if (state_nxt_s != state_r) begin
         wait_cnt_r <= {CNT_W{1'b0}};
      end else if ((TIMEOUT > 0) && ((state_r == FETCH) || (state_r == DATA))) begin
         wait_cnt_r <= wait_cnt_r + CNT_W'(1);
      end else begin
         wait_cnt_r <= {CNT_W{1'b0}};
      end
   end

   // Instruction/load capture registers and the sticky timeout flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         instr_r       <= 32'h0000_0000;
         load_r        <= 32'h0000_0000;
         timeout_err_r <= 1'b0;
      end else begin
         if ((state_r == FETCH) && bus.i_ack) begin
            instr_r <= bus.bus_rdata;
         end
         if ((state_r == DATA) && bus.d_ack && is_load_s) begin
            load_r <= load_ext_s;
         end
         if (state_nxt_s == ERROR) begin
            timeout_err_r <= 1'b1;
         end
      end
   end

   assign instruction_out = instr_r;
   assign load_data       = load_r;
   assign timeout_err     = timeout_err_r;

endmodule
